// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: runs one vector load/store from the MEM stage as R
// single-lane req/ack transfers on an N-bit memory port, gathers load lanes
// into rdata and stalls the pipeline until the vector completes.
// Optional feature: define VMEM_LANE_MASK_EN to add req_lane_mask; disabled
// lanes are skipped on the bus and read back as zero.
module vector_mem_sequencer #(
  parameter int I = 32,
  parameter int N = 8,
  parameter int R = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [I-1:0]          req_addr,
  input  logic [R-1:0][N-1:0]   req_wdata,
`ifdef VMEM_LANE_MASK_EN
  input  logic [R-1:0]          req_lane_mask,
`endif
  output logic                  stall,
  output logic                  done,
  output logic [R-1:0][N-1:0]   rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [I-1:0]          mem_addr,
  output logic [N-1:0]          mem_wdata,
  input  logic                  mem_ack,
  input  logic [N-1:0]          mem_rdata
);

  localparam int KW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  lat_write;
  logic [I-1:0]          lat_addr;
  logic [R-1:0][N-1:0]   lat_wdata;
  logic [R-1:0]          new_mask;
  logic [R-1:0]          cur_mask;
  logic                  start;
  logic                  capture;
  logic                  first_found, next_found;
  logic [KW-1:0]         first_lane, next_lane;

`ifdef VMEM_LANE_MASK_EN
  logic [R-1:0] mask_q;

  // Lane mask is captured together with the rest of the request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mask_q <= '0;
    else if (start)
      mask_q <= req_lane_mask;
  end

  assign new_mask = req_lane_mask;
  assign cur_mask = mask_q;
`else
  assign new_mask = '1;
  assign cur_mask = '1;
`endif

  // Find the first enabled lane of a new request and the next enabled lane
  // after k; scanning downward leaves the lowest qualifying index.
  always_comb begin
    first_found = 1'b0;
    first_lane  = '0;
    next_found  = 1'b0;
    next_lane   = '0;
    for (int unsigned i = R; i > 0; i--) begin
      if (new_mask[i-1]) begin
        first_found = 1'b1;
        first_lane  = KW'(i-1);
      end
      if (cur_mask[i-1] && (KW'(i-1) > k_q)) begin
        next_found = 1'b1;
        next_lane  = KW'(i-1);
      end
    end
  end

  // Next-state and bus outputs; bus is idle (all zero) outside XFER.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    start     = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          start   = 1'b1;
          k_d     = first_lane;
          state_d = first_found ? XFER : DONE;
        end
      end
      XFER: begin
        mem_req   = 1'b1;
        mem_we    = lat_write;
        mem_addr  = lat_addr + I'(k_q);
        mem_wdata = lat_wdata[k_q];
        if (mem_ack) begin
          capture = ~lat_write;
          if (next_found) begin
            k_d = next_lane;
          end else begin
            k_d     = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = req_valid & ~done;

  // State and lane counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Request latch: later changes on req_* are ignored until the next IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (start) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Gather buffer: cleared when a load starts, held through stores and idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rdata <= '0;
    else if (start && !req_write)
      rdata <= '0;
    else if (capture)
      rdata[k_q] <= mem_rdata;
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: directed bench for vector_mem_sequencer with a
// small memory responder (read data = address low byte, programmable wait).
module tb_vector_mem_sequencer;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [5:0][7:0]   req_wdata;
`ifdef VMEM_LANE_MASK_EN
  logic [5:0]        req_lane_mask;
`endif
  logic              stall;
  logic              done;
  logic [5:0][7:0]   rdata;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int wait_cnt;

  vector_mem_sequencer #(.I(32), .N(8), .R(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
`ifdef VMEM_LANE_MASK_EN
    .req_lane_mask(req_lane_mask),
`endif
    .stall        (stall),
    .done         (done),
    .rdata        (rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (wait_cnt == ack_delay);
  assign mem_rdata = mem_addr[7:0];

  always @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= 0;
    else if (mem_req && !mem_ack)
      wait_cnt <= wait_cnt + 1;
    else
      wait_cnt <= 0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
`ifdef VMEM_LANE_MASK_EN
    req_lane_mask = '1;
`endif
    tick; tick;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_req got req=%b we=%b exp 0 0", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_bus got addr=%h wdata=%h exp 0 0", mem_addr, mem_wdata); end
    checks++; if (done !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_done_stall got done=%b stall=%b exp 0 0", done, stall); end
    checks++; if (rdata !== 48'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    req_valid = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_follow got %b exp 1", stall); end
    req_valid = 1'b0; #1;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_wrap_load;
    logic [31:0] ea;
    ack_delay = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hFFFF_FFFE;
    for (int c = 1; c <= 6; c++) begin
      tick;
      ea = 32'hFFFF_FFFE + 32'(c - 1);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea) begin errors++; $display("FAIL wrap_lane c=%0d got req=%b we=%b addr=%h exp 1 0 %h", c, mem_req, mem_we, mem_addr, ea); end
    end
    tick;
    checks++; if (done !== 1'b1 || rdata !== 48'h0302_0100_FFFE) begin errors++; $display("FAIL wrap_done got done=%b rdata=%h exp 1 03020100fffe", done, rdata); end
    req_valid = 1'b0;
    tick;
    checks++; if (done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL wrap_after got done=%b req=%b exp 0 0", done, mem_req); end
  endtask

  task automatic test_store;
    ack_delay = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100;
    for (int k = 0; k < 6; k++) req_wdata[k] = 8'(8'h11 * (k + 1));
    #1;
    checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL store_c0 got stall=%b req=%b exp 1 0", stall, mem_req); end
    for (int c = 1; c <= 6; c++) begin
      tick;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'(32'h100 + c - 1) ||
          mem_wdata !== 8'(8'h11 * c) || stall !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL store_lane c=%0d got req=%b we=%b addr=%h wdata=%h stall=%b done=%b exp 1 1 %h %h 1 0",
                 c, mem_req, mem_we, mem_addr, mem_wdata, stall, done, 32'(32'h100 + c - 1), 8'(8'h11 * c));
      end
    end
    tick;
    checks++; if (done !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL store_done got done=%b stall=%b req=%b exp 1 0 0", done, stall, mem_req); end
    checks++; if (rdata !== 48'h0302_0100_FFFE) begin errors++; $display("FAIL store_rdata_hold got %h exp 03020100fffe", rdata); end
    req_valid = 1'b0;
    tick;
    checks++; if (done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL store_after got done=%b req=%b exp 0 0", done, mem_req); end
  endtask

  task automatic test_load_wait;
    logic [31:0] ea;
    ack_delay = 2;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20;
    for (int c = 1; c <= 18; c++) begin
      tick;
      ea = 32'h20 + 32'((c - 1) / 3);
      if (c == 1) begin
        checks++; if (rdata !== 48'h0) begin errors++; $display("FAIL load_clear got %h exp 0", rdata); end
      end
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea || done !== 1'b0) begin errors++; $display("FAIL load_wait_lane c=%0d got req=%b we=%b addr=%h done=%b exp 1 0 %h 0", c, mem_req, mem_we, mem_addr, done, ea); end
      if (c == 5) begin req_addr = 32'hDEAD_0000; req_write = 1'b1; end
    end
    tick;
    checks++; if (done !== 1'b1 || rdata !== 48'h2524_2322_2120) begin errors++; $display("FAIL load_wait_done got done=%b rdata=%h exp 1 252423222120", done, rdata); end
    req_valid = 1'b0; ack_delay = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    ack_delay = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
    for (int k = 0; k < 6; k++) req_wdata[k] = 8'(8'hA0 + k);
    for (int c = 1; c <= 4; c++) begin
      tick;
      checks++; if (mem_addr !== 32'(32'h40 + c - 1) || mem_wdata !== 8'(8'hA0 + c - 1)) begin errors++; $display("FAIL rmid_pre c=%0d got addr=%h wdata=%h exp %h %h", c, mem_addr, mem_wdata, 32'(32'h40 + c - 1), 8'(8'hA0 + c - 1)); end
    end
    reset = 1'b1; #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin errors++; $display("FAIL rmid_bus got req=%b we=%b addr=%h wdata=%h exp 0 0 0 0", mem_req, mem_we, mem_addr, mem_wdata); end
    checks++; if (rdata !== 48'h0 || done !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL rmid_state got rdata=%h done=%b stall=%b exp 0 0 1", rdata, done, stall); end
    tick;
    checks++; if (done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rmid_held got done=%b req=%b exp 0 0", done, mem_req); end
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(32'h40 + c - 1) || mem_wdata !== 8'(8'hA0 + c - 1)) begin errors++; $display("FAIL rmid_restart c=%0d got req=%b addr=%h wdata=%h exp 1 %h %h", c, mem_req, mem_addr, mem_wdata, 32'(32'h40 + c - 1), 8'(8'hA0 + c - 1)); end
    end
    tick;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_done got %b exp 1", done); end
    req_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    ack_delay = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200;
    for (int k = 0; k < 6; k++) req_wdata[k] = 8'(8'h30 + k);
    for (int c = 1; c <= 6; c++) begin
      tick;
      checks++; if (mem_we !== 1'b1 || mem_addr !== 32'(32'h200 + c - 1)) begin errors++; $display("FAIL b2b_store c=%0d got we=%b addr=%h exp 1 %h", c, mem_we, mem_addr, 32'(32'h200 + c - 1)); end
    end
    tick;
    checks++; if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_done1 got done=%b stall=%b exp 1 0", done, stall); end
    req_write = 1'b0; req_addr = 32'h300;
    tick;
    checks++; if (mem_req !== 1'b0 || done !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL b2b_idle got req=%b done=%b stall=%b exp 0 0 1", mem_req, done, stall); end
    for (int c = 1; c <= 6; c++) begin
      tick;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'(32'h300 + c - 1)) begin errors++; $display("FAIL b2b_load c=%0d got req=%b we=%b addr=%h exp 1 0 %h", c, mem_req, mem_we, mem_addr, 32'(32'h300 + c - 1)); end
    end
    tick;
    checks++; if (done !== 1'b1 || rdata !== 48'h0504_0302_0100) begin errors++; $display("FAIL b2b_done2 got done=%b rdata=%h exp 1 050403020100", done, rdata); end
    req_valid = 1'b0;
    tick;
  endtask

`ifdef VMEM_LANE_MASK_EN
  task automatic test_lane_mask;
    logic [31:0] ea [3];
    ea[0] = 32'h50; ea[1] = 32'h52; ea[2] = 32'h55;
    ack_delay = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50; req_lane_mask = 6'b100101;
    for (int c = 1; c <= 3; c++) begin
      tick;
      checks++; if (mem_req !== 1'b1 || mem_addr !== ea[c-1]) begin errors++; $display("FAIL mask_lane c=%0d got req=%b addr=%h exp 1 %h", c, mem_req, mem_addr, ea[c-1]); end
    end
    tick;
    checks++; if (done !== 1'b1 || rdata !== 48'h5500_0052_0050) begin errors++; $display("FAIL mask_done got done=%b rdata=%h exp 1 550000520050", done, rdata); end
    req_valid = 1'b0;
    tick;
    req_valid = 1'b1; req_lane_mask = 6'b000000;
    tick;
    checks++; if (done !== 1'b1 || mem_req !== 1'b0 || rdata !== 48'h0) begin errors++; $display("FAIL mask_zero got done=%b req=%b rdata=%h exp 1 0 0", done, mem_req, rdata); end
    req_valid = 1'b0; req_lane_mask = '1;
    tick;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_wrap_load;
    test_store;
    test_load_wait;
    test_reset_mid;
    test_back_to_back;
`ifdef VMEM_LANE_MASK_EN
    test_lane_mask;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Serializes one vector memory operation from the MEM stage into R single-lane transfers on an N-bit memory port. Issues lane accesses over a req/ack handshake, gathers read lanes into an R×N result, and holds a stall to the pipeline until the whole vector completes. Sits between the EX/MEM pipeline register outputs (address, write data, write/read controls) and data memory.

## Interface
- I, 32, address width
- N, 8, lane width in bits (one memory word)
- R, 6, number of lanes per vector
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  MEM stage holds a vector load or store (MemWriteM | MemtoRegM)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  I  base address of lane 0
- req_wdata  in  [R-1:0][N-1:0]  store data; lane k at req_wdata[k]
- req_lane_mask  in  R  lane enables (only with VMEM_LANE_MASK_EN)
- stall  out  1  freeze IF..MEM registers; combinational = req_valid & ~done
- done  out  1  one-cycle pulse, operation complete
- rdata  out  [R-1:0][N-1:0]  gathered load result
- mem_req  out  1  lane transfer request
- mem_we  out  1  lane write enable
- mem_addr  out  I  lane address
- mem_wdata  out  N  lane write data
- mem_ack  in  1  memory accepts/completes current lane
- mem_rdata  in  N  read data, valid when mem_ack=1 and mem_we=0

## Operation
- States: IDLE, XFER, DONE.
- IDLE: on req_valid=1 at a clock edge, latch req_write, req_addr, req_wdata (and mask) into internal registers; lane counter k = first enabled lane (0 without mask); go XFER. On a load, clear rdata to 0 at the same edge. Later changes on req_* are ignored until the next IDLE.
- XFER: mem_req=1, mem_we=latched write, mem_addr=base+k (modulo 2^I, wraps past all-ones), mem_wdata=latched wdata[k]. Outputs stable while mem_ack=0. On edge with mem_ack=1: load captures mem_rdata into rdata[k]; advance k to next enabled lane; if k was last enabled lane go DONE, else stay XFER.
- DONE: mem_req=0, done=1 for exactly one cycle, stall drops (pipeline advances this edge); next state IDLE unconditionally, so the same operation is never relaunched.
- Outside XFER: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- rdata holds its value through stores and IDLE until the next load starts.
- req_valid deasserted mid-operation: operation still runs to DONE (latched request).

## Timing
- Cycle 0: req_valid=1 in IDLE. Cycles 1..R: XFER with single-cycle ack. Cycle R+1: done=1. Minimum latency R+1 cycles to done; each mem_ack wait cycle adds one.
- mem_ack combinational same cycle as mem_req is legal; one lane per cycle max.
- mem_ack outside XFER ignored.
- Reset (any time, including mid-XFER): state IDLE, k=0, done=0, rdata=0, all mem_* outputs 0 immediately; stall then follows req_valid.

## Configuration
- VMEM_LANE_MASK_EN defined: req_lane_mask port exists, latched in IDLE; disabled lanes get no bus cycle and read as 0 in rdata on loads; mask all zeros → IDLE→DONE directly (done at cycle 1, no mem_req).
- Undefined: no mask port; all R lanes always transferred in order 0..R-1.

## Test plan
- Store, base 0x100, wdata lanes 0x11..0x66, mem_ack tied 1 → mem_addr 0x100..0x105 with data 0x11..0x66 on cycles 1..6, done at cycle 7, stall high cycles 0..6.
- Load, base 0x20, memory returns addr low byte, ack delayed 2 cycles per lane → rdata = {0x25,0x24,0x23,0x22,0x21,0x20}, done at cycle 19, mem_addr stable during waits.
- Load, base 0xFFFFFFFE → lane addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, 0x2, 0x3.
- Reset asserted during lane 3 of a store → mem_req 0 immediately, rdata 0, no done; after release with req_valid=1, operation restarts from lane 0.
- Back-to-back: store then load with req_valid held high → second op latched in the IDLE cycle after done, no lane of first op repeated.
- With VMEM_LANE_MASK_EN, load mask 6'b100101 → only addrs base+0, base+2, base+5 requested, rdata lanes 1,3,4 = 0, done at cycle 4; mask 0 → done at cycle 1.
